// File: rtl/serdes_pkg.sv
// Definitions shared by the serializer and deserializer ends of the link:
// frame state encoding, default frame geometry and the parity helper.
package serdes_pkg;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2,
    ST_SYNC = 2'd3
  } serdes_state_t;

  localparam int               SERDES_DATA_W       = 8;
  localparam int               SERDES_SYNC_W       = 8;
  localparam logic [7:0]       SERDES_SYNC_PATTERN = 8'hD4;

  // Callers zero-extend narrower words; the zero bits do not change the XOR.
  function automatic logic serdes_parity(input logic [63:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/serdes_sync_match.sv
// Sliding sync-word shift register and comparator. The match output looks at
// the word including the bit being shifted in this cycle.
module serdes_sync_match
  import serdes_pkg::*;
#(
  parameter int                SYNC_W       = SERDES_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(SERDES_SYNC_PATTERN)
) (
  input  logic clk,
  input  logic rst,
  input  logic shift_en,
  input  logic clr,
  input  logic bit_in,
  output logic match
);

  logic [SYNC_W-1:0] sr_reg;
  logic [SYNC_W-1:0] sr_next;

  assign sr_next[0] = bit_in;
  for (genvar gi = 1; gi < SYNC_W; gi++) begin : g_shift
    assign sr_next[gi] = sr_reg[gi-1];
  end

  assign match = (sr_next == SYNC_PATTERN);

  // Clear beats shift so a lost-lock cycle leaves no partial word behind.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr_reg <= '0;
    end else if (shift_en) begin
      sr_reg <= sr_next;
    end
  end

endmodule

// File: rtl/serdes_deserializer.sv
// Serial-to-parallel receiver: hunts for the sync word, captures
// sync + data + even-parity frames and presents each word on a one-deep
// valid/ready output register with parity-error and overrun reporting.
module serdes_deserializer
  import serdes_pkg::*;
#(
  parameter int                DATA_W       = SERDES_DATA_W,
  parameter int                SYNC_W       = SERDES_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(SERDES_SYNC_PATTERN),
  parameter int                LOSS_THRESH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdi,
  input  logic              sdi_en,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_par_err,
  output logic              locked,
  output logic              overrun,
  input  logic              ovr_clr
);

  localparam int CNT_MAX = (DATA_W > SYNC_W) ? DATA_W : SYNC_W;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

  serdes_state_t     state_reg, state_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [MISS_W-1:0] miss_cnt_reg, miss_cnt_next;
  logic [MISS_W-1:0] miss_inc;
  logic [DATA_W-1:0] data_sr_reg, data_sr_next;
  logic [DATA_W-1:0] rx_data_reg, rx_data_next;
  logic              rx_valid_reg, rx_valid_next;
  logic              rx_par_err_reg, rx_par_err_next;
  logic              locked_reg, locked_next;
  logic              overrun_reg, overrun_next;
  logic              sync_shift, sync_clr, sync_match;

  serdes_sync_match #(
    .SYNC_W      (SYNC_W),
    .SYNC_PATTERN(SYNC_PATTERN)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .shift_en(sync_shift),
    .clr     (sync_clr),
    .bit_in  (sdi),
    .match   (sync_match)
  );

  assign miss_inc = miss_cnt_reg + MISS_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_HUNT;
      bit_cnt_reg    <= '0;
      miss_cnt_reg   <= '0;
      data_sr_reg    <= '0;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      rx_par_err_reg <= 1'b0;
      locked_reg     <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      miss_cnt_reg   <= miss_cnt_next;
      data_sr_reg    <= data_sr_next;
      rx_data_reg    <= rx_data_next;
      rx_valid_reg   <= rx_valid_next;
      rx_par_err_reg <= rx_par_err_next;
      locked_reg     <= locked_next;
      overrun_reg    <= overrun_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    miss_cnt_next   = miss_cnt_reg;
    data_sr_next    = data_sr_reg;
    rx_data_next    = rx_data_reg;
    rx_valid_next   = rx_valid_reg;
    rx_par_err_next = rx_par_err_reg;
    locked_next     = locked_reg;
    overrun_next    = overrun_reg & ~ovr_clr;
    sync_shift      = 1'b0;
    sync_clr        = 1'b0;

    // Acceptance first; a load below in the same cycle re-asserts valid.
    if (rx_valid_reg && rx_ready) begin
      rx_valid_next = 1'b0;
    end

    if (sdi_en) begin
      unique case (state_reg)
        ST_HUNT: begin
          sync_shift = 1'b1;
          if (sync_match) begin
            state_next    = ST_DATA;
            locked_next   = 1'b1;
            bit_cnt_next  = '0;
            miss_cnt_next = '0;
          end
        end
        ST_DATA: begin
          data_sr_next = DATA_W'({data_sr_reg, sdi});
          if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
            state_next   = ST_PAR;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end
        ST_PAR: begin
          if (!rx_valid_reg || rx_ready) begin
            rx_data_next    = data_sr_reg;
            rx_par_err_next = serdes_parity(64'(data_sr_reg)) ^ sdi;
            rx_valid_next   = 1'b1;
          end else begin
            overrun_next = 1'b1;
          end
          state_next   = ST_SYNC;
          bit_cnt_next = '0;
        end
        ST_SYNC: begin
          sync_shift = 1'b1;
          if (bit_cnt_reg == CNT_W'(SYNC_W - 1)) begin
            bit_cnt_next = '0;
            if (sync_match) begin
              miss_cnt_next = '0;
              state_next    = ST_DATA;
            end else if (miss_inc < MISS_W'(LOSS_THRESH)) begin
              // Flywheel: tolerate an isolated corrupted sync word.
              miss_cnt_next = miss_inc;
              state_next    = ST_DATA;
            end else begin
              miss_cnt_next = '0;
              locked_next   = 1'b0;
              sync_clr      = 1'b1;
              state_next    = ST_HUNT;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end
        default: state_next = ST_HUNT;
      endcase
    end
  end

  assign rx_data    = rx_data_reg;
  assign rx_valid   = rx_valid_reg;
  assign rx_par_err = rx_par_err_reg;
  assign locked     = locked_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_serdes_deserializer.sv
// Scoreboard bench for serdes_deserializer: stimulus pushes expected words,
// a negedge monitor pops and compares on every accepted output word.
module tb_serdes_deserializer;
  import serdes_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sdi = 1'b0;
  logic       sdi_en = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       rx_par_err;
  logic       locked;
  logic       overrun;
  logic       ovr_clr = 1'b0;

  int checks = 0;
  int failures = 0;
  int pushes = 0;
  int pops = 0;
  bit gap = 1'b0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  serdes_deserializer dut (
    .clk       (clk),
    .rst       (rst),
    .sdi       (sdi),
    .sdi_en    (sdi_en),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_par_err(rx_par_err),
    .locked    (locked),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Monitor: every handshake pops one expected word.
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL word unexpected actual=%0h/%0b expected=none", rx_data, rx_par_err);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        pops++;
        if ({rx_data, rx_par_err} !== e) begin
          failures++;
          $display("FAIL word actual=%0h/%0b expected=%0h/%0b", rx_data, rx_par_err, e[8:1], e[0]);
        end else begin
          $display("ok   word data=%0h par_err=%0b", rx_data, rx_par_err);
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    sdi = b;
    sdi_en = 1'b1;
    @(posedge clk); #1;
    sdi_en = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_frame(input logic [7:0] s, input logic [7:0] d, input logic p, input bit deliver);
    send_byte(s);
    send_byte(d);
    if (deliver) begin
      exp_q.push_back({d, (^d) ^ p});
      pushes++;
    end
    send_bit(p);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [4:0] noise;
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] noise;
    noise = 5'b10110;
    idle(3);
    rst = 1'b0;
    #1;
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_par_err", rx_par_err, 0);
    check("reset_locked", locked, 0);
    check("reset_overrun", overrun, 0);

    // Clean frame after noise.
    rx_ready = 1'b1;
    for (int i = 4; i >= 0; i--) send_bit(noise[i]);
    send_byte(8'hD4);
    check("clean_locked", locked, 1);
    send_byte(8'h3C);
    check("clean_valid_before_par", rx_valid, 0);
    exp_q.push_back({8'h3C, 1'b0});
    pushes++;
    send_bit(1'b0);
    check("clean_valid_latency", rx_valid, 1);
    check("clean_data", rx_data, 8'h3C);
    idle(2);

    // Parity error.
    send_frame(8'hD4, 8'h3C, 1'b1, 1'b1);
    check("parerr_flag", rx_par_err, 1);
    check("parerr_locked", locked, 1);
    idle(2);

    // Overrun with consumer stalled.
    rx_ready = 1'b0;
    send_frame(8'hD4, 8'h3C, 1'b0, 1'b1);
    check("ovr_first_no_overrun", overrun, 0);
    send_frame(8'hD4, 8'h81, 1'b0, 1'b0);
    check("ovr_overrun", overrun, 1);
    check("ovr_data_held", rx_data, 8'h3C);
    check("ovr_valid_held", rx_valid, 1);
    ovr_clr = 1'b1;
    idle(1);
    ovr_clr = 1'b0;
    check("ovr_cleared", overrun, 0);
    rx_ready = 1'b1;
    idle(1);
    check("ovr_valid_dropped", rx_valid, 0);

    // Flywheel then loss of lock.
    send_frame(8'h00, 8'hA5, 1'b0, 1'b1);
    check("fly_locked", locked, 1);
    send_byte(8'h00);
    check("loss_unlocked", locked, 0);
    check("loss_state_hunt", dut.state_reg == ST_HUNT, 1);
    send_frame(8'hD4, 8'h5A, 1'b0, 1'b1);
    check("relock_locked", locked, 1);
    idle(2);

    // Gapped strobe.
    gap = 1'b1;
    send_frame(8'hD4, 8'h3C, 1'b0, 1'b1);
    gap = 1'b0;
    idle(2);
    check("gap_data", rx_data, 8'h3C);

    // Reset mid-frame.
    send_byte(8'hD4);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("midrst_rx_data", rx_data, 0);
    check("midrst_locked", locked, 0);
    check("midrst_valid", rx_valid, 0);
    send_frame(8'hD4, 8'hC3, 1'b0, 1'b1);
    idle(3);

    check("words_delivered", pops, pushes);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serdes_deserializer.md
# serdes_deserializer

Serial-to-parallel receiver for the SerDes link: the receive end matching the team's serializer. It hunts for a sync word in a strobed serial bit stream, then captures fixed-length frames of sync + data + even parity. Each frame's data word is presented on a one-deep valid/ready output register, with parity-error and overrun reporting. It sits between the pad-side serial input (`ui_in`/`uio_in` bit) and the on-chip parallel consumer inside the TinyTapeout top.

## Interface
- `DATA_W`, 8, data bits per frame
- `SYNC_W`, 8, sync word length in bits
- `SYNC_PATTERN`, 8'hD4, sync word, MSB first
- `LOSS_THRESH`, 2, consecutive sync mismatches that drop lock (≥1)

Ports:
- `clk`  in  1  single clock; all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `sdi`  in  1  serial data bit
- `sdi_en`  in  1  bit strobe; `sdi` consumed only on cycles with `sdi_en`=1
- `rx_data`  out  DATA_W  received word
- `rx_valid`  out  1  `rx_data`/`rx_par_err` valid
- `rx_ready`  in  1  consumer accepts when `rx_valid`&&`rx_ready`
- `rx_par_err`  out  1  parity error for the word in `rx_data`
- `locked`  out  1  frame alignment held
- `overrun`  out  1  sticky: a word was dropped
- `ovr_clr`  in  1  clears `overrun` (a same-cycle set wins)

## Operation
- Frame on the wire is MSB first: SYNC_W sync bits, DATA_W data bits, 1 parity bit. Frame length is 17 bits at defaults.
- Parity is even: a parity error exists when XOR(data, parity bit) = 1.
- States are HUNT, DATA, PAR and SYNC. Transitions happen only on `sdi_en` cycles. Cycles without `sdi_en` change nothing except the output handshake.
- HUNT: shift `sdi` into a SYNC_W shift register. When the register equals SYNC_PATTERN including the bit just shifted in, go to DATA, set `locked`=1, clear the bit counter and the miss counter.
- DATA: shift in DATA_W bits. On the last bit, go to PAR.
- PAR: consume the parity bit and attempt the output load, then go to SYNC.
  - Output register free (`rx_valid`=0, or `rx_ready`=1 this cycle): load `rx_data` and `rx_par_err`, set `rx_valid`=1.
  - Output register full and not accepted this cycle: drop the new word, keep the old word, set `overrun`=1.
- SYNC: collect SYNC_W bits, then compare.
  - Match: clear the miss counter and go to DATA.
  - Mismatch, miss counter +1 still below LOSS_THRESH: go to DATA anyway (flywheel).
  - Mismatch, miss counter reaches LOSS_THRESH: set `locked`=0, clear the shift register, go to HUNT.
- A partial sync seen in HUNT is never carried over into an aligned state. Overlapping matches inside HUNT are legal because the shift register slides bit by bit.
- Handshake: `rx_valid` clears on `rx_valid`&&`rx_ready` unless a load occurs in the same cycle, in which case the new word is presented with `rx_valid` held at 1. `rx_data` is stable while `rx_valid`=1 and not accepted.

## Timing
- Reset values: state HUNT, `rx_data`=0, `rx_valid`=0, `rx_par_err`=0, `locked`=0, `overrun`=0, all counters 0.
- A reset mid-frame discards the partial word and any held output word.
- `locked` rises on the clock edge that ends the `sdi_en` cycle carrying the last sync bit; it is visible the next cycle.
- `rx_valid` rises registered one cycle after the `sdi_en` cycle carrying the parity bit. Latency from the parity bit to `rx_valid` is 1 clock.
- Minimum frame period is 17 clocks at defaults, with `sdi_en` held high.
- A consumer holding `rx_ready`=1 never causes overrun.
- All outputs are registered. There is no combinational path from `sdi`/`sdi_en` to any output. `rx_ready` affects only the next-state logic.

## Structure
- Shared package `serdes_pkg` holds:
  - the state enum (HUNT/DATA/PAR/SYNC);
  - `SERDES_SYNC_PATTERN`, `SERDES_DATA_W` and `SERDES_SYNC_W` defaults, shared with the serializer so both ends agree;
  - a `serdes_parity` function.
- Sub-module `serdes_sync_match`: the SYNC_W shift register, the comparator and the clear input. It is used in HUNT and SYNC.
- The FSM, counters and output register live in `serdes_deserializer`.

## Test plan
- **Clean frame:** 5 noise bits 1,0,1,1,0, then D4, 3C, parity 0, with `sdi_en`=1 and `rx_ready`=1. Expect `locked`=1 after the sync bits; `rx_data`=8'h3C, `rx_par_err`=0 and `rx_valid` one cycle after the parity bit.
- **Parity error:** frame D4, 3C, parity 1. Expect `rx_data`=8'h3C with `rx_par_err`=1.
- **Overrun:** two back-to-back frames 3C then 81 (parity 0 each) with `rx_ready`=0. Expect `rx_data` to stay 8'h3C and `overrun`=1. Then `ovr_clr` pulse gives `overrun`=0; `rx_ready` pulse gives `rx_valid`=0.
- **Flywheel and loss of lock:** locked stream, then one frame with sync 00. Expect `locked` to stay 1 and the data word still delivered. Then a second consecutive bad sync: expect `locked`=0 and state HUNT. A later D4 relocks.
- **Gaps and reset:** `sdi_en` toggled 1/0 through a full frame gives the same result as the clean case. `rst` asserted after 4 data bits clears all outputs to 0. The next full frame is received correctly.
